// File: rtl/cpu_br_pkg.sv
// ============================================================================
// Module  : cpu_br_pkg
// Brief   : Shared branch-type codes, FSM encoding and hazard stall constants
//           for the ID-stage branch resolver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_br_pkg;

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BGEZ = 2'b10;
    localparam logic [1:0] BR_BLTZ = 2'b11;

    localparam logic [1:0] NO_STALL       = 2'd0;
    localparam logic [1:0] LOAD_EX_STALL  = 2'd2;
    localparam logic [1:0] ALU_EX_STALL   = 2'd1;
    localparam logic [1:0] LOAD_MEM_STALL = 2'd1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } br_state_t;

    // Only the two-register compares read rt.
    function automatic logic br_uses_rt(input logic [1:0] br_type);
        return (br_type == BR_BEQ) || (br_type == BR_BNE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/br_hazard_detect.sv
// ============================================================================
// Module  : br_hazard_detect
// Brief   : Combinational count of stall cycles a branch in ID needs before
//           its source operands can reach the comparator.
// Revision: 1.0
// ============================================================================
`default_nettype none

module br_hazard_detect
    import cpu_br_pkg::*;
(
    input  logic [1:0] id_br_type,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_wr_en,
    input  logic [4:0] ex_wr_reg,
    input  logic       ex_is_load,
    input  logic       mem_wr_en,
    input  logic [4:0] mem_wr_reg,
    input  logic       mem_is_load,
    output logic [1:0] need
);

    // MEM-stage ALU results are already forwarded, so only a MEM load costs a cycle.
    function automatic logic [1:0] src_need(
        input logic [4:0] r,
        input logic       ex_we,
        input logic [4:0] ex_reg,
        input logic       ex_ld,
        input logic       mem_we,
        input logic [4:0] mem_reg,
        input logic       mem_ld
    );
        logic [1:0] n;
        n = NO_STALL;
        if (r != 5'd0) begin
            if (ex_we && (ex_reg == r))
                n = ex_ld ? LOAD_EX_STALL : ALU_EX_STALL;
            else if (mem_we && (mem_reg == r) && mem_ld)
                n = LOAD_MEM_STALL;
        end
        return n;
    endfunction

    logic [1:0] w_need_rs;
    logic [1:0] w_need_rt;

    always_comb begin
        w_need_rs = src_need(id_rs, ex_wr_en, ex_wr_reg, ex_is_load,
                             mem_wr_en, mem_wr_reg, mem_is_load);
        w_need_rt = NO_STALL;
        if (br_uses_rt(id_br_type))
            w_need_rt = src_need(id_rt, ex_wr_en, ex_wr_reg, ex_is_load,
                                 mem_wr_en, mem_wr_reg, mem_is_load);
        need = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
// ============================================================================
// Module  : branch_resolve_ctrl
// Brief   : ID-stage branch sequencer: stalls for operand hazards, resolves
//           from comparator flags, drives PC-select / IF flush. Optional
//           statistics counters when BR_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve_ctrl
    import cpu_br_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_br_valid,
    input  logic [1:0]        id_br_type,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_kill,
    input  logic              ex_wr_en,
    input  logic [4:0]        ex_wr_reg,
    input  logic              ex_is_load,
    input  logic              mem_wr_en,
    input  logic [4:0]        mem_wr_reg,
    input  logic              mem_is_load,
    input  logic              cmp_equal,
    input  logic              cmp_bgez,
    output logic              stall,
    output logic              br_taken,
    output logic              if_flush,
    output logic [STAT_W-1:0] stat_br,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_stall
);

    br_state_t  r_state;
    br_state_t  w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_need;
    logic       w_resolve;
    logic       w_cond;

    br_hazard_detect u_hazard (
        .id_br_type  (id_br_type),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_wr_en    (ex_wr_en),
        .ex_wr_reg   (ex_wr_reg),
        .ex_is_load  (ex_is_load),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_reg  (mem_wr_reg),
        .mem_is_load (mem_is_load),
        .need        (w_need)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The hazard count is only consulted on entry from IDLE; WAIT just counts down.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        w_resolve   = 1'b0;
        if (!rst_n) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 2'd0;
        end else if (id_kill) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (id_br_valid) begin
                        if (w_need == NO_STALL) begin
                            w_resolve = 1'b1;
                        end else begin
                            stall       = 1'b1;
                            w_cnt_nxt   = w_need - 2'd1;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        stall     = 1'b1;
                        w_cnt_nxt = r_cnt - 2'd1;
                    end else begin
                        w_resolve   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (id_br_type)
            BR_BEQ:  w_cond = cmp_equal;
            BR_BNE:  w_cond = !cmp_equal;
            BR_BGEZ: w_cond = cmp_bgez;
            BR_BLTZ: w_cond = !cmp_bgez;
            default: w_cond = 1'b0;
        endcase
    end

    assign br_taken = w_resolve & w_cond;
    assign if_flush = br_taken & (DELAY_SLOT == 0);

`ifdef BR_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br    <= '0;
            stat_taken <= '0;
            stat_stall <= '0;
        end else begin
            if (w_resolve && (stat_br != STAT_MAX))
                stat_br <= stat_br + STAT_ONE;
            if (br_taken && (stat_taken != STAT_MAX))
                stat_taken <= stat_taken + STAT_ONE;
            if (stall && (stat_stall != STAT_MAX))
                stat_stall <= stat_stall + STAT_ONE;
        end
    end
`else
    assign stat_br    = '0;
    assign stat_taken = '0;
    assign stat_stall = '0;
`endif

endmodule

`default_nettype wire
